// File: rtl/l2_ctrl_if.sv
// L1-side request/response and backing-memory bus bundle for the L2 controller.
interface l2_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic             req_valid_i;
    logic             req_ready_o;
    logic [31:0]      req_addr_i;
    logic             req_we_i;
    logic [31:0]      req_wdata_i;
    logic             resp_valid_o;
    logic [31:0]      resp_rdata_o;
    logic             flush_i;
    logic             mem_req_o;
    logic             mem_we_o;
    logic [31:0]      mem_addr_o;
    logic [31:0]      mem_wdata_o;
    logic             mem_ack_i;
    logic [31:0]      mem_rdata_i;
    logic [CNT_W-1:0] hit_cnt_o;
    logic [CNT_W-1:0] miss_cnt_o;

    // Controller side.
    modport slave (
        input  req_valid_i, req_addr_i, req_we_i, req_wdata_i, flush_i, mem_ack_i, mem_rdata_i,
        output req_ready_o, resp_valid_o, resp_rdata_o, mem_req_o, mem_we_o, mem_addr_o,
               mem_wdata_o, hit_cnt_o, miss_cnt_o
    );

    // L1 / backing-memory side.
    modport master (
        output req_valid_i, req_addr_i, req_we_i, req_wdata_i, flush_i, mem_ack_i, mem_rdata_i,
        input  req_ready_o, resp_valid_o, resp_rdata_o, mem_req_o, mem_we_o, mem_addr_o,
               mem_wdata_o, hit_cnt_o, miss_cnt_o
    );
endinterface

// File: rtl/l2_ctrl.sv
// Direct-mapped, one-word-per-line, write-through / read-allocate L2 controller.
module l2_ctrl #(
    parameter int unsigned INDEX_W = 6,
    parameter int unsigned CNT_W   = 16
) (
    input  logic     clk,
    input  logic     rst_n,
    l2_ctrl_if.slave bus
);
    localparam int unsigned LINES = 1 << INDEX_W;
    localparam int unsigned TAG_W = 30 - INDEX_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {StIdle, StLookup, StMemRd, StMemWr, StResp} state_e;

    state_e           state_q, state_d;
    logic [29:0]      waddr_q, waddr_d;   // word address, byte offset dropped
    logic             we_q, we_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [LINES-1:0] valid_q, valid_d;
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      data_mem [LINES];
    logic [TAG_W-1:0] tag_rd_q;
    logic [31:0]      data_rd_q;

    logic               ready;
    logic               rd_en, tag_we, data_we;
    logic [31:0]        data_wdata;
    logic [INDEX_W-1:0] idx, rd_idx;
    logic [TAG_W-1:0]   tag;
    logic               hit;

    assign idx    = waddr_q[INDEX_W-1:0];
    assign tag    = waddr_q[29:INDEX_W];
    assign rd_idx = bus.req_addr_i[INDEX_W+1:2];
    assign hit    = valid_q[idx] && (tag_rd_q == tag);

    // Next-state, array controls and bus outputs.
    always_comb begin
        state_d    = state_q;
        waddr_d    = waddr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        valid_d    = valid_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        rd_en      = 1'b0;
        tag_we     = 1'b0;
        data_we    = 1'b0;
        data_wdata = wdata_q;
        ready      = 1'b0;

        bus.req_ready_o  = 1'b0;
        bus.resp_valid_o = 1'b0;
        bus.resp_rdata_o = '0;
        bus.mem_req_o    = 1'b0;
        bus.mem_we_o     = 1'b0;
        bus.mem_addr_o   = '0;
        bus.mem_wdata_o  = '0;

        unique case (state_q)
            StIdle: begin
                // Held low while in reset even though the state already reads IDLE.
                ready = rst_n && !bus.flush_i;
                if (bus.flush_i) begin
                    valid_d = '0;
                end else if (bus.req_valid_i) begin
                    waddr_d = bus.req_addr_i[31:2];
                    we_d    = bus.req_we_i;
                    wdata_d = bus.req_wdata_i;
                    rdata_d = '0;
                    rd_en   = 1'b1;
                    state_d = StLookup;
                end
            end
            StLookup: begin
                if (hit) begin
                    hit_cnt_d = (hit_cnt_q == CNT_MAX) ? hit_cnt_q : hit_cnt_q + 1'b1;
                    if (we_q) begin
                        data_we = 1'b1;
                        state_d = StMemWr;
                    end else begin
                        rdata_d = data_rd_q;
                        state_d = StResp;
                    end
                end else begin
                    miss_cnt_d = (miss_cnt_q == CNT_MAX) ? miss_cnt_q : miss_cnt_q + 1'b1;
                    state_d    = we_q ? StMemWr : StMemRd;
                end
            end
            StMemRd: begin
                bus.mem_req_o  = 1'b1;
                bus.mem_addr_o = {waddr_q, 2'b00};
                if (bus.mem_ack_i) begin
                    tag_we       = 1'b1;
                    data_we      = 1'b1;
                    data_wdata   = bus.mem_rdata_i;
                    valid_d[idx] = 1'b1;
                    rdata_d      = bus.mem_rdata_i;
                    state_d      = StResp;
                end
            end
            StMemWr: begin
                bus.mem_req_o   = 1'b1;
                bus.mem_we_o    = 1'b1;
                bus.mem_addr_o  = {waddr_q, 2'b00};
                bus.mem_wdata_o = wdata_q;
                if (bus.mem_ack_i) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                bus.resp_valid_o = 1'b1;
                bus.resp_rdata_o = rdata_q;
                state_d          = StIdle;
            end
            default: state_d = StIdle;
        endcase

        bus.req_ready_o = ready;
        bus.hit_cnt_o   = hit_cnt_q;
        bus.miss_cnt_o  = miss_cnt_q;
    end

    // Tag/data arrays: synchronous read at acceptance, writes at hit-update or fill.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            tag_rd_q  <= tag_mem[rd_idx];
            data_rd_q <= data_mem[rd_idx];
        end
        if (tag_we) begin
            tag_mem[idx] <= tag;
        end
        if (data_we) begin
            data_mem[idx] <= data_wdata;
        end
    end

    // Control state, latched request, valid bits and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            waddr_q    <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            valid_q    <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            waddr_q    <= waddr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            valid_q    <= valid_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end
endmodule
